bsg_fpu_classify_arb: RTL and testbench



---
 rtl/bsg_fpu_classify_arb.sv | 145 ++++++++++++++
 tb/tb_bsg_fpu_classify_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fpu_classify_arb.sv
// Round-robin arbitrated binary16 classifier shared by num_req_p requesters.
// One-entry output register holds the one-hot fclass result tagged with the winner.
module bsg_fpu_classify_arb #(
   parameter int unsigned num_req_p = 4,
   parameter int unsigned e_p       = 5,
   parameter int unsigned m_p       = 10,
   localparam int unsigned op_w_lp    = 1 + e_p + m_p,
   localparam int unsigned tag_w_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1,
   localparam int unsigned class_w_lp = 16
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [num_req_p-1:0]         v_i,
   input  logic [num_req_p*op_w_lp-1:0] data_i,
   output logic [num_req_p-1:0]         ready_o,
   output logic                         v_o,
   output logic [class_w_lp-1:0]        class_o,
   output logic [tag_w_lp-1:0]          tag_o,
   input  logic                         yumi_i
);

   localparam int unsigned sum_w_lp = tag_w_lp + 1;

   typedef enum logic [0:0] {
      empty_s = 1'b0,
      full_s  = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [tag_w_lp-1:0]     ptr_q, ptr_d;
   logic [class_w_lp-1:0]   class_q, class_d;
   logic [tag_w_lp-1:0]     tag_q, tag_d;

   logic                    accept;
   logic                    gnt_found;
   logic                    grant;
   logic [tag_w_lp-1:0]     gnt_idx;
   logic [tag_w_lp-1:0]     cand;
   logic [sum_w_lp-1:0]     idx_sum;
   logic [op_w_lp-1:0]      op_sel;

   // fclass bit order: -inf,-norm,-sub,-zero,+zero,+sub,+norm,+inf,sNaN,qNaN
   function automatic logic [class_w_lp-1:0] classify(input logic [op_w_lp-1:0] op);
      logic              sign;
      logic [e_p-1:0]    ex;
      logic [m_p-1:0]    mn;
      logic              ex_max, ex_zero, mn_zero;
      logic [class_w_lp-1:0] cls;
      sign    = op[op_w_lp-1];
      ex      = op[op_w_lp-2 -: e_p];
      mn      = op[m_p-1:0];
      ex_max  = &ex;
      ex_zero = ~|ex;
      mn_zero = ~|mn;
      cls     = '0;
      cls[0]  = ex_max & mn_zero & sign;
      cls[1]  = ~ex_max & ~ex_zero & sign;
      cls[2]  = ex_zero & ~mn_zero & sign;
      cls[3]  = ex_zero & mn_zero & sign;
      cls[4]  = ex_zero & mn_zero & ~sign;
      cls[5]  = ex_zero & ~mn_zero & ~sign;
      cls[6]  = ~ex_max & ~ex_zero & ~sign;
      cls[7]  = ex_max & mn_zero & ~sign;
      cls[8]  = ex_max & ~mn_zero & ~mn[m_p-1];
      cls[9]  = ex_max & mn[m_p-1];
      return cls;
   endfunction

   assign accept = (state_q == empty_s) | yumi_i;

   // First valid requester at or after the pointer, searching upward with wrap
   always_comb begin : arb
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx_sum   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < num_req_p; k++) begin
         idx_sum = sum_w_lp'(ptr_q) + sum_w_lp'(k);
         if (idx_sum >= sum_w_lp'(num_req_p)) begin
            idx_sum = idx_sum - sum_w_lp'(num_req_p);
         end
         cand = tag_w_lp'(idx_sum);
         if (!gnt_found && v_i[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign grant = accept & gnt_found & ~reset_i;

   always_comb begin : op_mux
      op_sel = '0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         if (gnt_idx == tag_w_lp'(i)) begin
            op_sel = data_i[i*op_w_lp +: op_w_lp];
         end
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= empty_s;
         ptr_q   <= '0;
         class_q <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         class_q <= class_d;
         tag_q   <= tag_d;
      end
   end

   // Next state: a grant always refills, otherwise a dequeue empties
   always_comb begin : next_state
      state_d = state_q;
      ptr_d   = ptr_q;
      class_d = class_q;
      tag_d   = tag_q;
      if (grant) begin
         state_d = full_s;
         class_d = classify(op_sel);
         tag_d   = gnt_idx;
         ptr_d   = (gnt_idx == tag_w_lp'(num_req_p - 1)) ? '0 : gnt_idx + tag_w_lp'(1);
      end else if (yumi_i && (state_q == full_s)) begin
         state_d = empty_s;
      end
   end

   always_comb begin : outputs
      ready_o = '0;
      if (grant) begin
         ready_o[gnt_idx] = 1'b1;
      end
      v_o     = (state_q == full_s);
      class_o = class_q;
      tag_o   = tag_q;
   end

   yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
      else $error("yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_fpu_classify_arb.sv
// Scoreboard bench for bsg_fpu_classify_arb: reference classifier, round-robin model,
// per-requester operand queues and a result queue compared when the consumer dequeues.
module tb_bsg_fpu_classify_arb;

   localparam int unsigned N  = 4;
   localparam int unsigned TW = 2;

   logic            clk = 1'b0;
   logic            reset_i;
   logic [N-1:0]    v_i;
   logic [N*16-1:0] data_i;
   logic [N-1:0]    ready_o;
   logic            v_o;
   logic [15:0]     class_o;
   logic [TW-1:0]   tag_o;
   logic            yumi_i;

   always #5 clk = ~clk;

   bsg_fpu_classify_arb #(.num_req_p(N), .e_p(5), .m_p(10)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .v_i     (v_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .v_o     (v_o),
      .class_o (class_o),
      .tag_o   (tag_o),
      .yumi_i  (yumi_i)
   );

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [15:0]   cls;
   } exp_t;

   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        sb[$];
   logic [15:0] req_q[N][$];
   int          m_ptr = 0;
   bit          m_v = 1'b0;
   bit [N-1:0]  gnt_seen = '0;
   bit          yumi_en = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_class(input logic [15:0] x);
      int b;
      if (x[14:10] == 5'h1f) b = (x[9:0] == 10'd0) ? (x[15] ? 0 : 7) : (x[9] ? 9 : 8);
      else if (x[14:10] == 5'd0) b = (x[9:0] == 10'd0) ? (x[15] ? 3 : 4) : (x[15] ? 2 : 5);
      else b = x[15] ? 1 : 6;
      return 16'(1) << b;
   endfunction

   // Monitor on the falling edge: check outputs, dequeue results, advance the model
   always @(negedge clk) begin : mon
      logic [N-1:0] exp_rdy;
      bit           accept;
      int           g;
      exp_t         e;
      exp_rdy = '0;
      g = -1;
      check_eq("v_o", 32'(v_o), 32'(m_v));
      accept = !m_v || yumi_i;
      if (!reset_i && accept) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (g < 0 && v_i[j]) g = j;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_eq("ready_o", 32'(ready_o), 32'(exp_rdy));
      if (v_o && yumi_i) begin
         check_eq("sb_nonempty", 32'(sb.size() != 0), 32'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("tag_o", 32'(tag_o), 32'(e.tag));
            check_eq("class_o", 32'(class_o), 32'(e.cls));
         end
      end
      gnt_seen = v_i & ready_o;
      if (reset_i) begin
         m_v = 1'b0;
         m_ptr = 0;
         sb.delete();
      end else if (g >= 0) begin
         e.tag = TW'(g);
         e.cls = ref_class(data_i[g*16 +: 16]);
         sb.push_back(e);
         m_v = 1'b1;
         m_ptr = (g + 1) % N;
      end else if (yumi_i) begin
         m_v = 1'b0;
      end
   end

   // One clock: retire granted operands, present the next ones, drive the consumer
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (gnt_seen[i]) v_i[i] = 1'b0;
         if (!v_i[i] && req_q[i].size() > 0) begin
            data_i[i*16 +: 16] = req_q[i].pop_front();
            v_i[i] = 1'b1;
         end
      end
      yumi_i = yumi_en && v_o;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      step();
      step();
      reset_i = 1'b0;
   endtask

   logic [15:0]   saved_c;
   logic [TW-1:0] saved_t;
   bit            drained;

   initial begin
      reset_i = 1'b1;
      v_i     = '0;
      data_i  = '0;
      yumi_i  = 1'b0;
      step();
      step();
      @(negedge clk);
      check_eq("rst_v_o", 32'(v_o), 32'(0));
      check_eq("rst_class_o", 32'(class_o), 32'(0));
      check_eq("rst_tag_o", 32'(tag_o), 32'(0));
      check_eq("rst_ready_o", 32'(ready_o), 32'(0));
      step();
      reset_i = 1'b0;

      // Single requester, one operand per cycle
      yumi_en = 1'b1;
      begin
         logic [15:0] ops[7] = '{16'h7C00, 16'hFC00, 16'h3C00, 16'h8000, 16'h0001, 16'h7D00, 16'h7E00};
         foreach (ops[i]) req_q[0].push_back(ops[i]);
      end
      run(12);

      // All four requesters continuously valid
      do_reset();
      begin
         logic [15:0] ops4[N][5] = '{
            '{16'h83FF, 16'h0400, 16'hFC00, 16'h7E00, 16'h0000},
            '{16'h0400, 16'h7C00, 16'h8001, 16'h7C01, 16'hBC00},
            '{16'h8000, 16'h03FF, 16'h7FFF, 16'hFBFF, 16'h3555},
            '{16'hFE00, 16'h7BFF, 16'h0200, 16'h8400, 16'hFC01}};
         for (int r = 0; r < N; r++)
            for (int k = 0; k < 5; k++) req_q[r].push_back(ops4[r][k]);
      end
      run(26);

      // Backpressure with a held result, then same-cycle dequeue and grant
      do_reset();
      yumi_en = 1'b0;
      req_q[0].push_back(16'h3C00);
      step();
      step();
      saved_c = class_o;
      saved_t = tag_o;
      check_eq("bp_class_o", 32'(class_o), 32'(16'h0040));
      req_q[1].push_back(16'h7C00);
      req_q[2].push_back(16'hFC00);
      run(4);
      check_eq("bp_class_hold", 32'(class_o), 32'(saved_c));
      check_eq("bp_tag_hold", 32'(tag_o), 32'(saved_t));
      yumi_en = 1'b1;
      step();
      @(negedge clk);
      check_eq("bp_grant1", 32'(ready_o), 32'(4'b0010));
      run(5);

      // Pointer wrap from 3 to 0
      do_reset();
      req_q[2].push_back(16'h0001);
      run(4);
      req_q[0].push_back(16'h8000);
      req_q[2].push_back(16'h7E00);
      step();
      @(negedge clk);
      check_eq("wrap_grant0", 32'(ready_o), 32'(4'b0001));
      step();
      @(negedge clk);
      check_eq("wrap_grant2", 32'(ready_o), 32'(4'b0100));
      run(4);

      // Reset while a result is held and all requesters are valid
      for (int r = 0; r < N; r++)
         for (int k = 0; k < 3; k++) req_q[r].push_back(16'(16'h3C00 + 16'(r*8 + k)));
      run(3);
      reset_i = 1'b1;
      step();
      @(negedge clk);
      check_eq("midrst_v_o", 32'(v_o), 32'(0));
      check_eq("midrst_ready_o", 32'(ready_o), 32'(0));
      step();
      reset_i = 1'b0;
      @(negedge clk);
      check_eq("postrst_grant0", 32'(ready_o), 32'(4'b0001));

      // Drain everything with a bounded wait
      drained = 1'b0;
      for (int c = 0; c < 200 && !drained; c++) begin
         step();
         drained = (v_i == '0) && !v_o && (sb.size() == 0) &&
                   (req_q[0].size() == 0) && (req_q[1].size() == 0) &&
                   (req_q[2].size() == 0) && (req_q[3].size() == 0);
      end
      check_eq("drain", 32'(drained), 32'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
